seq_lock: RTL and testbench

Parametrised sequence-code lock for the FSM-lock hardware-security path. Accepts a stream of SYM_W-bit symbols, compares the last KEY_LEN symbols against a key on an explicit enter strobe, and asserts `unlock` for a bounded hold time. Counts failed attempts and enforces a timed lockout after MAX_FAIL consecutive failures. Generalises the fixed 5-step two-input lock to any key length and symbol width, with enter-framed attempts, auto-relock and brute-force throttling.

---
 rtl/seq_lock.sv | 161 ++++++++++++++++
 tb/tb_seq_lock.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_lock.sv
// Sequence-code lock: compares the last KEY_LEN symbols against KEY on an enter
// strobe, holds unlock for a bounded time, and throttles brute force with a timed lockout.
module seq_lock #(
    parameter int SYM_W          = 2,
    parameter int KEY_LEN        = 5,
    parameter logic [KEY_LEN*SYM_W-1:0] KEY = {2'd0, 2'd1, 2'd0, 2'd1, 2'd1},
    parameter int HOLD_CYCLES    = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1),
    localparam int CNT_W   = $clog2(KEY_LEN + 2),
    localparam int TMR_MAX = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES,
    localparam int TMR_W   = $clog2(TMR_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym,
    input  logic              enter,
    output logic              unlock,
    output logic              lockout,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic [CNT_W-1:0]  sym_cnt
);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(KEY_LEN);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(KEY_LEN + 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  TMR_HOLD  = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_LOCK  = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);

    state_t              state_reg, state_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic [FAIL_W-1:0]   fail_reg, fail_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                unlock_reg, lockout_reg;
    logic [SYM_W-1:0]    hist_reg [KEY_LEN];
    logic                hist_shift, hist_clear;
    logic [KEY_LEN-1:0]  sym_match;
    logic                key_match;

    // Slot 0 holds the newest symbol, which pairs with the key's last (LSB) symbol.
    genvar gi;
    generate
        for (gi = 0; gi < KEY_LEN; gi++) begin : g_match
            assign sym_match[gi] = (hist_reg[gi] == KEY[gi*SYM_W +: SYM_W]);
        end
    endgenerate

    assign key_match = &sym_match;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        fail_next  = fail_reg;
        cnt_next   = cnt_reg;
        hist_shift = 1'b0;
        hist_clear = 1'b0;
        case (state_reg)
            S_LOCKED: begin
                if (enter) begin
                    hist_clear = 1'b1;
                    cnt_next   = '0;
                    if (key_match && (cnt_reg == CNT_FULL)) begin
                        state_next = S_UNLOCKED;
                        fail_next  = '0;
                        timer_next = TMR_HOLD;
                    end else if (fail_reg == FAIL_LAST) begin
                        state_next = S_LOCKOUT;
                        fail_next  = FAIL_MAX;
                        timer_next = TMR_LOCK;
                    end else begin
                        fail_next = fail_reg + FAIL_W'(1);
                    end
                end else if (sym_valid) begin
                    hist_shift = 1'b1;
                    if (cnt_reg != CNT_SAT) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_UNLOCKED: begin
                // A zero hold time means the lock stays open until relocked by enter.
                if (enter) begin
                    state_next = S_LOCKED;
                    timer_next = '0;
                    hist_clear = 1'b1;
                    cnt_next   = '0;
                end else if (HOLD_CYCLES != 0) begin
                    if (timer_reg == TMR_ONE) begin
                        state_next = S_LOCKED;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg - TMR_ONE;
                    end
                end
            end
            S_LOCKOUT: begin
                if (timer_reg == TMR_ONE) begin
                    state_next = S_LOCKED;
                    timer_next = '0;
                    fail_next  = '0;
                    cnt_next   = '0;
                    hist_clear = 1'b1;
                end else begin
                    timer_next = timer_reg - TMR_ONE;
                end
            end
            default: begin
                state_next = S_LOCKED;
                timer_next = '0;
                fail_next  = '0;
                cnt_next   = '0;
                hist_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_LOCKED;
            timer_reg   <= '0;
            fail_reg    <= '0;
            cnt_reg     <= '0;
            unlock_reg  <= 1'b0;
            lockout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            fail_reg    <= fail_next;
            cnt_reg     <= cnt_next;
            unlock_reg  <= (state_next == S_UNLOCKED);
            lockout_reg <= (state_next == S_LOCKOUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_LEN; i++) hist_reg[i] <= '0;
        end else if (hist_clear) begin
            for (int i = 0; i < KEY_LEN; i++) hist_reg[i] <= '0;
        end else if (hist_shift) begin
            hist_reg[0] <= sym;
            for (int i = 1; i < KEY_LEN; i++) hist_reg[i] <= hist_reg[i-1];
        end
    end

    assign unlock   = unlock_reg;
    assign lockout  = lockout_reg;
    assign fail_cnt = fail_reg;
    assign sym_cnt  = cnt_reg;

endmodule

// File: tb/tb_seq_lock.sv
// Bench for seq_lock: default build and a HOLD_CYCLES=0 build share the same stimulus
// and are each compared every cycle against a behavioural model of the lock.
module tb_seq_lock;

    localparam int SYM_W    = 2;
    localparam int KEY_LEN  = 5;
    localparam int KEY_INT  = 'b00_01_00_01_01;
    localparam int BAD_INT  = 'b00_01_00_01_00;
    localparam int LONG_INT = 'b01_00_01_00_01_01;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sym_valid = 1'b0;
    logic [1:0] sym = '0;
    logic       enter = 1'b0;
    logic       unlock0, lockout0, unlock1, lockout1;
    logic [1:0] fail_cnt0, fail_cnt1;
    logic [2:0] sym_cnt0, sym_cnt1;

    int checks = 0;
    int errors = 0;

    // Model state per build: 0 locked, 1 unlocked, 2 lockout.
    int hold_of[2] = '{8, 0};
    int m_mode[2];
    int m_rem[2];
    int m_fail[2];
    int m_n[2];
    int m_val[2];

    seq_lock u_dut0 (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym), .enter(enter),
        .unlock(unlock0), .lockout(lockout0), .fail_cnt(fail_cnt0), .sym_cnt(sym_cnt0)
    );

    seq_lock #(.HOLD_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym), .enter(enter),
        .unlock(unlock1), .lockout(lockout1), .fail_cnt(fail_cnt1), .sym_cnt(sym_cnt1)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_rem[d] = 0; m_fail[d] = 0; m_n[d] = 0; m_val[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit sv, input int s, input bit en);
        case (m_mode[d])
            0: begin
                if (en) begin
                    if (m_n[d] == KEY_LEN && m_val[d] == KEY_INT) begin
                        m_mode[d] = 1; m_fail[d] = 0; m_rem[d] = hold_of[d];
                    end else begin
                        m_fail[d]++;
                        if (m_fail[d] == MAX_FAIL) begin
                            m_mode[d] = 2; m_rem[d] = LOCK_CYC;
                        end
                    end
                    m_n[d] = 0; m_val[d] = 0;
                end else if (sv) begin
                    // Last KEY_LEN symbols kept as a base-4 number.
                    m_val[d] = (m_val[d] * (1 << SYM_W) + s) % (1 << (KEY_LEN * SYM_W));
                    m_n[d]++;
                end
            end
            1: begin
                if (en) m_mode[d] = 0;
                else if (hold_of[d] > 0) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) m_mode[d] = 0;
                end
            end
            default: begin
                m_rem[d]--;
                if (m_rem[d] == 0) begin
                    m_mode[d] = 0; m_fail[d] = 0; m_n[d] = 0; m_val[d] = 0;
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int d);
        return (m_n[d] > KEY_LEN + 1) ? KEY_LEN + 1 : m_n[d];
    endfunction

    task automatic check_all();
        chk("unlock0",   32'(unlock0),   32'(m_mode[0] == 1));
        chk("lockout0",  32'(lockout0),  32'(m_mode[0] == 2));
        chk("fail_cnt0", 32'(fail_cnt0), 32'(m_fail[0]));
        chk("sym_cnt0",  32'(sym_cnt0),  32'(exp_cnt(0)));
        chk("unlock1",   32'(unlock1),   32'(m_mode[1] == 1));
        chk("lockout1",  32'(lockout1),  32'(m_mode[1] == 2));
        chk("fail_cnt1", 32'(fail_cnt1), 32'(m_fail[1]));
        chk("sym_cnt1",  32'(sym_cnt1),  32'(exp_cnt(1)));
    endtask

    task automatic step(input bit sv, input int s, input bit en);
        sym_valid = sv; sym = 2'(s); enter = en;
        @(posedge clk);
        model_step(0, sv, s, en);
        model_step(1, sv, s, en);
        #1;
        sym_valid = 1'b0; enter = 1'b0;
        check_all();
        if (en)
            $display("attempt @%0t: unlock=%0b/%0b lockout=%0b/%0b fail_cnt=%0d/%0d",
                     $time, unlock0, unlock1, lockout0, lockout1, fail_cnt0, fail_cnt1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic send(input int val, input int len);
        for (int i = len - 1; i >= 0; i--) step(1, (val >> (i * SYM_W)) & 3, 0);
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 check_all();
        repeat (2) @(posedge clk);
        #1 check_all();
        rst_n = 1'b1;

        // Correct key: 8-cycle unlock on the default build, indefinite on the other.
        send(KEY_INT, KEY_LEN);
        step(0, 0, 1);
        idle(10);

        // Three wrong attempts lead to lockout; the key is ignored meanwhile.
        async_reset();
        for (int a = 0; a < 3; a++) begin
            send(BAD_INT, KEY_LEN);
            step(0, 0, 1);
        end
        idle(4);
        send(KEY_INT, KEY_LEN);
        step(0, 0, 1);
        idle(10);

        // Over-length and sub-length entries fail.
        async_reset();
        send(LONG_INT, 6);
        step(0, 0, 1);
        send(KEY_INT >> SYM_W, 4);
        step(0, 0, 1);

        // Early relock by enter; symbols ignored while unlocked.
        async_reset();
        send(KEY_INT, KEY_LEN);
        step(0, 0, 1);
        step(1, 2, 0);
        step(1, 3, 0);
        step(0, 0, 1);
        idle(3);

        // enter with sym_valid discards the symbol; a pass clears the fail count.
        async_reset();
        send(KEY_INT, KEY_LEN);
        step(1, 3, 1);
        step(0, 0, 1);
        idle(10);
        send(BAD_INT, KEY_LEN);
        step(0, 0, 1);
        send(BAD_INT, KEY_LEN);
        step(0, 0, 1);
        send(KEY_INT, KEY_LEN);
        step(0, 0, 1);
        idle(9);

        // Reset mid-lockout and mid-unlock.
        async_reset();
        for (int a = 0; a < 3; a++) step(0, 0, 1);
        idle(5);
        async_reset();
        send(KEY_INT, KEY_LEN);
        step(0, 0, 1);
        idle(3);
        async_reset();

        // Zero-hold build stays open 100 cycles until enter.
        send(KEY_INT, KEY_LEN);
        step(0, 0, 1);
        idle(100);
        step(0, 0, 1);
        idle(2);

        // Randomised traffic with frequent correct-key attempts.
        async_reset();
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) begin
                send(KEY_INT, KEY_LEN);
                step($urandom_range(0, 1), $urandom_range(0, 3), 1);
            end else if (r == 1) begin
                step($urandom_range(0, 1), $urandom_range(0, 3), 1);
            end else begin
                step($urandom_range(0, 1), $urandom_range(0, 3), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
